// File: rtl/mlp_seq_classifier_pkg.sv
// Shared dimensions, word types, FSM states and default RedWine
// weights for the time-multiplexed MLP classifier.
package mlp_seq_pkg;

  localparam int N_IN_DEF   = 11;
  localparam int IN_W_DEF   = 4;
  localparam int N_HID_DEF  = 2;
  localparam int N_OUT_DEF  = 6;
  localparam int W_W_DEF    = 8;
  localparam int B_W_DEF    = 16;
  localparam int ACC0_W_DEF = 13;
  localparam int HID_W_DEF  = 12;
  localparam int ACC1_W_DEF = 20;
  localparam int OUT_W_DEF  = 19;

  typedef logic signed [W_W_DEF-1:0]    w_t;
  typedef logic signed [B_W_DEF-1:0]    b_t;
  typedef logic signed [ACC0_W_DEF-1:0] acc0_t;
  typedef logic signed [ACC1_W_DEF-1:0] acc1_t;

  typedef enum logic [1:0] {
    IDLE,
    L0,
    L1,
    DONE
  } state_t;

  localparam w_t W0 [N_HID_DEF][N_IN_DEF] = '{
    '{-8'sd13, -8'sd68, -8'sd26, -8'sd23, -8'sd17, 8'sd15,
      -8'sd8, 8'sd30, -8'sd24, 8'sd15, 8'sd46},
    '{-8'sd23, 8'sd0, -8'sd3, -8'sd19, 8'sd6, -8'sd3,
      8'sd28, 8'sd26, -8'sd13, -8'sd23, -8'sd17}
  };

  localparam b_t B0 [N_HID_DEF] = '{16'sd468, 16'sd342};

  localparam w_t W1 [N_OUT_DEF][N_HID_DEF] = '{
    '{-8'sd75, 8'sd1},
    '{-8'sd19, 8'sd10},
    '{8'sd2, 8'sd51},
    '{8'sd18, 8'sd17},
    '{8'sd30, -8'sd24},
    '{8'sd25, -8'sd55}
  };

  localparam b_t B1 [N_OUT_DEF] = '{
    16'sd5452, 16'sd4388, 16'sd1284,
    16'sd4148, 16'sd350, -16'sd5639
  };

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mlp_seq_classifier_mac.sv
// Signed MAC with bias load, clear and relu+truncate output.
// Feature input is unsigned and zero-extended before multiply.
module mlp_seq_mac #(
  parameter int X_W   = 4,
  parameter int W_W   = 8,
  parameter int B_W   = 16,
  parameter int ACC_W = 13,
  parameter int OUT_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_load,
  input  logic                    i_en,
  input  logic signed [B_W-1:0]   i_bias,
  input  logic        [X_W-1:0]   i_x,
  input  logic signed [W_W-1:0]   i_w,
  output logic        [OUT_W-1:0] o_relu
);

  localparam int P_W = X_W + 1 + W_W;
  localparam int S_W = (P_W > ACC_W) ? P_W : ACC_W;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [S_W-1:0]   w_prod;
  logic signed [S_W-1:0]   w_sum;

  assign w_prod = S_W'($signed({1'b0, i_x})) * S_W'(i_w);
  assign w_sum  = S_W'(r_acc) + w_prod;

  // accumulator wraps at ACC_W bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= ACC_W'(i_bias);
    end else if (i_en) begin
      r_acc <= ACC_W'(w_sum);
    end
  end

  assign o_relu = r_acc[ACC_W-1] ? '0 : OUT_W'(r_acc);

endmodule

// File: rtl/mlp_seq_classifier.sv
// Time-multiplexed 2-layer MLP classifier: one MAC per cycle,
// running argmax, valid/ready on both sides.
module mlp_seq_classifier
  import mlp_seq_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int N_HID  = N_HID_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int W_W    = W_W_DEF,
  parameter int B_W    = B_W_DEF,
  parameter int ACC0_W = ACC0_W_DEF,
  parameter int HID_W  = HID_W_DEF,
  parameter int ACC1_W = ACC1_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int IDX_W  = $clog2(N_OUT),
  parameter logic signed [W_W-1:0] PW0 [N_HID][N_IN]  = W0,
  parameter logic signed [B_W-1:0] PB0 [N_HID]        = B0,
  parameter logic signed [W_W-1:0] PW1 [N_OUT][N_HID] = W1,
  parameter logic signed [B_W-1:0] PB1 [N_OUT]        = B1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   inp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_OUT*OUT_W-1:0] predo,
  output logic [IDX_W-1:0]       out
);

  localparam int K_W = $clog2(imax(N_IN, N_HID) + 1);
  localparam int N_W = $clog2(imax(N_HID, N_OUT) + 1);

  state_t r_state;
  state_t w_next;

  logic [N_IN*IN_W-1:0] r_x;
  logic [K_W-1:0]       r_k;
  logic [N_W-1:0]       r_n;
  logic [HID_W-1:0]     r_hid [N_HID];
  logic [OUT_W-1:0]     r_pred [N_OUT];
  logic [OUT_W-1:0]     r_best;
  logic [IDX_W-1:0]     r_idx;

  logic w_accept;
  logic w_k0_end;
  logic w_k1_end;
  logic w_h_last;
  logic w_o_last;
  logic w_fin;
  logic w_wr0;
  logic w_wr1;

  logic        [IN_W-1:0]  w_x0;
  logic        [HID_W-1:0] w_x1;
  logic signed [W_W-1:0]   w_w0;
  logic signed [W_W-1:0]   w_w1;
  logic signed [B_W-1:0]   w_b0;
  logic signed [B_W-1:0]   w_b1;
  logic        [HID_W-1:0] w_h;
  logic        [OUT_W-1:0] w_y;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_k0_end = (r_k == K_W'(N_IN));
  assign w_k1_end = (r_k == K_W'(N_HID));
  assign w_h_last = (r_n == N_W'(N_HID - 1));
  assign w_o_last = (r_n == N_W'(N_OUT - 1));
  // r_n == N_OUT marks the settle cycle after the last output write
  assign w_fin    = (r_n == N_W'(N_OUT));
  assign w_wr0    = (r_state == L0) && w_k0_end;
  assign w_wr1    = (r_state == L1) && !w_fin && w_k1_end;

  always_comb begin
    w_x0 = '0;
    w_x1 = '0;
    w_w0 = '0;
    w_w1 = '0;
    w_b0 = PB0[0];
    w_b1 = PB1[0];
    for (int i = 0; i < N_IN; i++) begin
      if (r_k == K_W'(i)) w_x0 = r_x[i*IN_W +: IN_W];
    end
    for (int h = 0; h < N_HID; h++) begin
      if (r_k == K_W'(h)) w_x1 = r_hid[h];
      for (int i = 0; i < N_IN; i++) begin
        if (r_n == N_W'(h) && r_k == K_W'(i)) w_w0 = PW0[h][i];
      end
      if (!w_accept && h > 0 && r_n == N_W'(h - 1)) w_b0 = PB0[h];
    end
    for (int o = 0; o < N_OUT; o++) begin
      for (int h = 0; h < N_HID; h++) begin
        if (r_n == N_W'(o) && r_k == K_W'(h)) w_w1 = PW1[o][h];
      end
      if (r_state == L1 && o > 0 && r_n == N_W'(o - 1)) w_b1 = PB1[o];
    end
  end

  mlp_seq_mac #(
    .X_W  (IN_W),
    .W_W  (W_W),
    .B_W  (B_W),
    .ACC_W(ACC0_W),
    .OUT_W(HID_W)
  ) u_mac0 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (1'b0),
    .i_load(w_accept || (w_wr0 && !w_h_last)),
    .i_en  ((r_state == L0) && !w_k0_end),
    .i_bias(w_b0),
    .i_x   (w_x0),
    .i_w   (w_w0),
    .o_relu(w_h)
  );

  mlp_seq_mac #(
    .X_W  (HID_W),
    .W_W  (W_W),
    .B_W  (B_W),
    .ACC_W(ACC1_W),
    .OUT_W(OUT_W)
  ) u_mac1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_load((w_wr0 && w_h_last) || (w_wr1 && !w_o_last)),
    .i_en  ((r_state == L1) && !w_fin && !w_k1_end),
    .i_bias(w_b1),
    .i_x   (w_x1),
    .i_w   (w_w1),
    .o_relu(w_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = L0;
      L0:      if (w_k0_end && w_h_last) w_next = L1;
      L1:      if (w_fin) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    out       = r_idx;
    predo     = '0;
    for (int o = 0; o < N_OUT; o++) begin
      predo[(N_OUT-1-o)*OUT_W +: OUT_W] = r_pred[o];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_k    <= '0;
      r_n    <= '0;
      r_best <= '0;
      r_idx  <= '0;
      for (int h = 0; h < N_HID; h++) r_hid[h] <= '0;
      for (int o = 0; o < N_OUT; o++) r_pred[o] <= '0;
    end else if (w_accept) begin
      r_x <= inp;
      r_k <= '0;
      r_n <= '0;
    end else if (r_state == L0) begin
      if (w_k0_end) begin
        r_k <= '0;
        r_n <= w_h_last ? '0 : r_n + N_W'(1);
        for (int h = 0; h < N_HID; h++) begin
          if (r_n == N_W'(h)) r_hid[h] <= w_h;
        end
      end else begin
        r_k <= r_k + K_W'(1);
      end
    end else if (r_state == L1 && !w_fin) begin
      if (w_k1_end) begin
        r_k <= '0;
        r_n <= r_n + N_W'(1);
        for (int o = 0; o < N_OUT; o++) begin
          if (r_n == N_W'(o)) r_pred[o] <= w_y;
        end
        // strict compare keeps the lowest index on ties
        if (r_n == '0 || w_y > r_best) begin
          r_best <= w_y;
          r_idx  <= IDX_W'(r_n);
        end
      end else begin
        r_k <= r_k + K_W'(1);
      end
    end
  end

endmodule
